// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: fetch/decode/execute/memory/writeback with a memory-wait timeout.
// Define CPU_CTRL_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module cpu_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [4:0] rd,
    input  logic       branch,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       halted,
    output logic       illegal,
    output logic       bus_err
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic             set_illegal;
    logic             set_bus_err;

    function automatic logic decode_legal(input logic [6:0] op, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_R, OP_IMM, OP_JALR, OP_JAL, OP_AUIPC, OP_LUI: ok = 1'b1;
            OP_LOAD:   ok = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            OP_STORE:  ok = (f3 inside {3'b000, 3'b001, 3'b010});
            OP_BRANCH: ok = !(f3 inside {3'b010, 3'b011});
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign state       = cur_state;
    assign halted      = (cur_state == S_HALT);
    // Only meaningful while waiting: ready low in the last allowed cycle ends in a bus error.
    assign timeout_hit = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        next_state  = cur_state;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'd0;
        rf_we       = 1'b0;
        wb_sel      = 2'd0;
        case (cur_state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state  = S_HALT;
                    set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                if (decode_legal(opcode, funct3)) begin
                    next_state = S_EXEC;
                end else begin
                    next_state  = S_HALT;
                    set_illegal = (opcode != OP_SYSTEM);
                end
            end
            S_EXEC: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    next_state = S_MEM;
                end else if (opcode == OP_BRANCH) begin
                    pc_we      = 1'b1;
                    pc_sel     = branch ? 2'd1 : 2'd0;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_STORE);
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_we      = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (timeout_hit) begin
                    next_state  = S_HALT;
                    set_bus_err = 1'b1;
                end
            end
            S_WB: begin
                pc_we      = 1'b1;
                rf_we      = (rd != 5'd0);
                next_state = S_FETCH;
                if (opcode == OP_LOAD)
                    wb_sel = 2'd1;
                else if (opcode == OP_JAL || opcode == OP_JALR)
                    wb_sel = 2'd2;
                if (opcode == OP_JAL)
                    pc_sel = 2'd1;
                else if (opcode == OP_JALR)
                    pc_sel = 2'd2;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_HALT;
        endcase
    end

    // The wait counter restarts on every transition, so it only accumulates while a request is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state   <= S_IDLE;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            bus_err     <= 1'b0;
`ifdef CPU_CTRL_PERF_CNT_EN
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
`endif
        end else begin
            cur_state <= next_state;
            if (next_state != cur_state)
                wait_cnt <= '0;
            else if (cur_state == S_FETCH || cur_state == S_MEM)
                wait_cnt <= wait_cnt + 1'b1;
            illegal <= illegal | set_illegal;
            bus_err <= bus_err | set_bus_err;
`ifdef CPU_CTRL_PERF_CNT_EN
            if (cur_state != S_IDLE && cur_state != S_HALT)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_we)
                instret_cnt <= instret_cnt + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: a driver plays instructions with random memory delays,
// a reference model predicts each retire/halt, and a monitor compares what the core actually does.
module tb_cpu_ctrl_fsm;

    localparam int TMO = 16;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       branch;
    logic       imem_req, imem_ready, ir_we;
    logic       dmem_req, dmem_we, dmem_ready;
    logic       pc_we, rf_we, halted, illegal, bus_err;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] state;
`ifdef CPU_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    cpu_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .rd(rd), .branch(branch),
        .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .state(state), .halted(halted), .illegal(illegal), .bus_err(bus_err)
`ifdef CPU_CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_halt;
        logic       ill;
        logic       berr;
        logic       mem;
        logic       rf_we;
        logic       chk_wb;
        logic [1:0] pc_sel;
        logic [1:0] wb_sel;
        int         cycles;
        int         ireq;
        int         dreq;
        int         dwe;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int   cyc_n, ireq_n, dreq_n, dwe_n, stray_n, ret_n;
    bit   halt_seen;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Instruction-level model: what the core should do for one instruction given the memory delays.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                                   input logic br, input int idly, input int ddly);
        exp_t e;
        bit   is_store;
        e = '{default: 0};
        is_store = (op == OP_STORE);
        if (idly >= TMO) begin
            e.is_halt = 1; e.berr = 1; e.ireq = TMO;
            return e;
        end
        e.ireq = idly + 1;
        case (op)
            OP_R, OP_IMM, OP_AUIPC, OP_LUI: begin
                e.rf_we = (r != 0); e.chk_wb = 1; e.wb_sel = 0; e.pc_sel = 0; e.cycles = idly + 4;
            end
            OP_JAL: begin
                e.rf_we = (r != 0); e.chk_wb = 1; e.wb_sel = 2; e.pc_sel = 1; e.cycles = idly + 4;
            end
            OP_JALR: begin
                e.rf_we = (r != 0); e.chk_wb = 1; e.wb_sel = 2; e.pc_sel = 2; e.cycles = idly + 4;
            end
            OP_BRANCH: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    e.is_halt = 1; e.ill = 1;
                end else begin
                    e.pc_sel = br ? 2'd1 : 2'd0; e.cycles = idly + 3;
                end
            end
            OP_LOAD, OP_STORE: begin
                if ((op == OP_LOAD && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) ||
                    (is_store && f3 > 3'd2)) begin
                    e.is_halt = 1; e.ill = 1;
                end else begin
                    e.mem = 1;
                    if (ddly >= TMO) begin
                        e.is_halt = 1; e.berr = 1; e.dreq = TMO; e.dwe = is_store ? TMO : 0;
                    end else begin
                        e.dreq = ddly + 1;
                        e.dwe  = is_store ? ddly + 1 : 0;
                        if (is_store) begin
                            e.pc_sel = 0; e.cycles = idly + ddly + 4;
                        end else begin
                            e.rf_we = (r != 0); e.chk_wb = 1; e.wb_sel = 1; e.pc_sel = 0;
                            e.cycles = idly + ddly + 5;
                        end
                    end
                end
            end
            OP_SYSTEM: e.is_halt = 1;
            default: begin
                e.is_halt = 1; e.ill = 1;
            end
        endcase
        return e;
    endfunction

    // Monitor samples mid-low-phase, after the driver's changes have settled.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            cyc_n = 0; ireq_n = 0; dreq_n = 0; dwe_n = 0; stray_n = 0; ret_n = 0;
            halt_seen = 0;
        end else begin
            if (state != 3'd0 && !halted) cyc_n++;
            if (imem_req) ireq_n++;
            if (dmem_req) dreq_n++;
            if (dmem_req && dmem_we) dwe_n++;
            if ((pc_we && (imem_req || ir_we)) || (rf_we && !pc_we) || (dmem_we && !dmem_req) ||
                (ir_we && !imem_ready) ||
                (halted && (imem_req || dmem_req || pc_we || rf_we || ir_we)))
                stray_n++;
            if (pc_we) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_retire", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("retire_kind", 0, int'(e.is_halt));
                    checkOutput("pc_sel", int'(pc_sel), int'(e.pc_sel));
                    checkOutput("rf_we", int'(rf_we), int'(e.rf_we));
                    if (e.chk_wb) checkOutput("wb_sel", int'(wb_sel), int'(e.wb_sel));
                    checkOutput("latency", cyc_n, e.cycles);
                    checkOutput("imem_req_cycles", ireq_n, e.ireq);
                    checkOutput("dmem_req_cycles", dreq_n, e.dreq);
                    checkOutput("dmem_we_cycles", dwe_n, e.dwe);
                    checkOutput("stray_strobes", stray_n, 0);
`ifdef CPU_CTRL_PERF_CNT_EN
                    checkOutput("instret_cnt", int'(instret_cnt), ret_n);
`endif
                end
                ret_n++;
                cyc_n = 0; ireq_n = 0; dreq_n = 0; dwe_n = 0; stray_n = 0;
            end
            if (halted && !halt_seen) begin
                halt_seen = 1;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_halt", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("halt_kind", 1, int'(e.is_halt));
                    checkOutput("illegal", int'(illegal), int'(e.ill));
                    checkOutput("bus_err", int'(bus_err), int'(e.berr));
                    checkOutput("halt_imem_cycles", ireq_n, e.ireq);
                    checkOutput("halt_dmem_cycles", dreq_n, e.dreq);
                    checkOutput("halt_state", int'(state), 6);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                                 input logic br, input int idly, input int ddly);
        exp_t e;
        int   n;
        int   k;
        e = model(op, f3, r, br, idly, ddly);
        n = 0;
        while (!imem_req && n < 64) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            checkOutput("fetch_wait", 0, 1);
            resetDut();
            return;
        end
        sb.push_back(e);
        k = 0;
        while (1) begin
            if (k == idly) begin
                opcode = op; funct3 = f3; rd = r; branch = br;
                imem_ready = 1'b1;
                tick();
                imem_ready = 1'b0;
                break;
            end
            tick();
            k++;
            if (halted || !imem_req) break;
        end
        if (e.mem && !halted) begin
            n = 0;
            while (!dmem_req && !halted && n < 8) begin
                tick();
                n++;
            end
            if (dmem_req) begin
                k = 0;
                while (1) begin
                    if (k == ddly) begin
                        dmem_ready = 1'b1;
                        tick();
                        dmem_ready = 1'b0;
                        break;
                    end
                    tick();
                    k++;
                    if (halted || !dmem_req) break;
                end
            end
        end
        if (e.is_halt) begin
            n = 0;
            while (!halted && n < 40) begin
                tick();
                n++;
            end
            if (!halted) checkOutput("halt_wait", 0, 1);
            tick();
            resetDut();
        end
    endtask

    function automatic int rand_delay();
        int r;
        r = int'($urandom_range(0, 31));
        if (r < 24) return r % 4;
        if (r < 28) return int'($urandom_range(4, 12));
        return int'($urandom_range(14, 17));
    endfunction

    initial begin
        logic [6:0] ops [12];
        logic [6:0] op;
        int         n;
        ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL, OP_AUIPC, OP_LUI,
                OP_SYSTEM, 7'b1111111, OP_IMM};
        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; rd = 5'd0; branch = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_imem_req", int'(imem_req), 0);
        checkOutput("reset_pc_we", int'(pc_we), 0);
        checkOutput("reset_halted", int'(halted), 0);
        checkOutput("reset_illegal", int'(illegal), 0);
        checkOutput("reset_bus_err", int'(bus_err), 0);
        rst = 1'b0;
        #1;
        checkOutput("idle_after_reset", int'(state), 0);
        tick();
        checkOutput("fetch_after_idle", int'(state), 1);
        checkOutput("fetch_imem_req", int'(imem_req), 1);

        applyStimulus(OP_IMM, 3'd0, 5'd5, 1'b0, 0, 0);
        applyStimulus(OP_IMM, 3'd0, 5'd5, 1'b0, 0, 0);
        applyStimulus(OP_LOAD, 3'b010, 5'd3, 1'b0, 0, 3);
        applyStimulus(OP_BRANCH, 3'b000, 5'd7, 1'b1, 0, 0);
        applyStimulus(OP_BRANCH, 3'b000, 5'd7, 1'b0, 0, 0);
        applyStimulus(OP_JALR, 3'b000, 5'd0, 1'b0, 0, 0);
        applyStimulus(OP_JAL, 3'b000, 5'd1, 1'b0, 0, 0);
        applyStimulus(OP_STORE, 3'b010, 5'd0, 1'b0, 0, 0);
        applyStimulus(OP_LUI, 3'b000, 5'd0, 1'b0, 1, 0);
        applyStimulus(OP_IMM, 3'd0, 5'd1, 1'b0, TMO - 1, 0);
        applyStimulus(OP_IMM, 3'd0, 5'd1, 1'b0, TMO, 0);
        applyStimulus(OP_LOAD, 3'b000, 5'd4, 1'b0, 0, TMO - 1);
        applyStimulus(OP_STORE, 3'b001, 5'd4, 1'b0, 0, TMO);
        applyStimulus(7'b1111111, 3'd0, 5'd1, 1'b0, 0, 0);
        applyStimulus(OP_SYSTEM, 3'd0, 5'd0, 1'b0, 0, 0);
        applyStimulus(OP_LOAD, 3'b011, 5'd2, 1'b0, 0, 0);
        applyStimulus(OP_BRANCH, 3'b010, 5'd2, 1'b1, 0, 0);
        applyStimulus(OP_STORE, 3'b011, 5'd2, 1'b0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0)
                op = 7'($urandom);
            else
                op = ops[$urandom_range(0, 11)];
            applyStimulus(op, 3'($urandom), 5'($urandom), 1'($urandom), rand_delay(), rand_delay());
        end

        // Reset asserted while a load is stalled in the memory phase.
        n = 0;
        while (!imem_req && n < 64) begin
            tick();
            n++;
        end
        opcode = OP_LOAD; funct3 = 3'b010; rd = 5'd3;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        n = 0;
        while (!dmem_req && n < 8) begin
            tick();
            n++;
        end
        checkOutput("mem_phase_reached", int'(dmem_req), 1);
        tick();
        tick();
        checkOutput("sb_drained", sb.size(), 0);
        rst = 1'b1;
        #1;
        checkOutput("rst_dmem_req", int'(dmem_req), 0);
        checkOutput("rst_state", int'(state), 0);
        checkOutput("rst_illegal", int'(illegal), 0);
        checkOutput("rst_bus_err", int'(bus_err), 0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_idle", int'(state), 0);
        tick();
        checkOutput("rst_then_fetch", int'(state), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It drives instruction fetch, decode, ALU execute, data memory access and register writeback. It consumes opcode/funct3/rd from the instruction register and the ALU branch flag, and produces the strobes and mux selects for the PC, instruction register, register file and memory ports. It also contains a memory-wait timeout that halts the core on a hung bus.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before bus error (legal 2..255)
CNT_W, 8, width of wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-high reset
opcode  input  7  opcode field of latched instruction
funct3  input  3  funct3 field (used only for legality of LOAD/STORE/BRANCH)
rd  input  5  destination register index
branch  input  1  ALU branch-taken flag, valid in S_EXEC
imem_req  output  1  instruction fetch request
imem_ready  input  1  fetch data valid / request accepted
ir_we  output  1  latch instruction register
dmem_req  output  1  data memory request
dmem_we  output  1  data write (store) qualifier for dmem_req
dmem_ready  input  1  data access complete
pc_we  output  1  update PC (one-cycle pulse, marks instruction retire)
pc_sel  output  2  0=pc+4, 1=pc+imm (branch/JAL), 2=ALU_result (JALR)
rf_we  output  1  register file write enable
wb_sel  output  2  0=ALU_result, 1=load data, 2=pc+4
state  output  3  current state encoding
halted  output  1  high in S_HALT
illegal  output  1  sticky: halted on unsupported opcode/funct3
bus_err  output  1  sticky: halted on memory timeout

Behaviour:
- States and encoding: S_IDLE=0, S_FETCH=1, S_DECODE=2, S_EXEC=3, S_MEM=4, S_WB=5, S_HALT=6. State is registered. Strobes and selects decode combinationally from state, opcode and handshake inputs.
- Reset (async, any time, including mid-request): state=S_IDLE, wait counter=0, illegal=0, bus_err=0. All strobes are 0 while rst is high. S_IDLE lasts exactly one cycle after reset deasserts, then S_FETCH.
- S_FETCH: imem_req=1 held until imem_ready. In the imem_ready cycle ir_we=1 and the next state is S_DECODE.
- S_DECODE: one cycle, no strobes. Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111, 0010111, 0110111.
  - LOAD requires funct3 in {000,001,010,100,101}.
  - STORE requires funct3 in {000,001,010}.
  - BRANCH requires funct3 not in {010,011}.
  - SYSTEM (1110011) goes to S_HALT with illegal=0.
  - Any other case goes to S_HALT and sets illegal=1.
- S_EXEC: one cycle.
  - LOAD/STORE go to S_MEM.
  - BRANCH: pc_we=1, pc_sel=branch?1:0, next S_FETCH, no rf write.
  - All others go to S_WB.
- S_MEM: dmem_req=1; dmem_we=1 iff STORE. Request is held until dmem_ready.
  - STORE: in the ready cycle pc_we=1, pc_sel=0, next S_FETCH.
  - LOAD: next S_WB.
- S_WB: one cycle, next S_FETCH, pc_we=1.
  - rf_we=(rd!=0).
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
- Wait counter: clears on every state transition. Increments each cycle in S_FETCH/S_MEM while ready=0.
  - If ready=0 when the counter equals MEM_TIMEOUT-1: next state S_HALT and bus_err=1.
  - Ready in that same cycle wins: normal transition, no error.
- S_HALT: all strobes 0; remains until rst. illegal/bus_err hold their values.
- Latency with zero-wait memory (ready asserted in first request cycle), fetch to next fetch: ALU/LUI/AUIPC/JAL/JALR 4 cycles, BRANCH 3, STORE 4, LOAD 5.
- pc_we is asserted exactly once per retired instruction and never coincides with imem_req or ir_we.

Optional Feature:
CPU_CTRL_PERF_CNT_EN:
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle state!=S_IDLE and state!=S_HALT.
  - instret_cnt increments on each pc_we pulse.
  - Both wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADDI (opcode 0010011, rd=5), imem/dmem ready held 1 -> states 1,2,3,5,1. ir_we at cycle 1, rf_we=1 wb_sel=0 pc_we=1 pc_sel=0 in S_WB. 4 cycles per instruction.
- LW (funct3=010, rd=3), dmem_ready delayed 3 cycles -> dmem_req=1 dmem_we=0 for 4 cycles. Then S_WB with wb_sel=1, rf_we=1. No bus_err.
- BEQ with branch=1, then branch=0 -> S_EXEC pc_we=1 with pc_sel=1, then pc_sel=0. rf_we never asserted. Next state S_FETCH.
- JALR with rd=0 -> S_WB: rf_we=0, pc_sel=2, wb_sel=2, pc_we=1.
- imem_ready held 0, MEM_TIMEOUT=16 -> imem_req high 16 cycles, then S_HALT, bus_err=1, halted=1. Repeat with ready asserted in cycle 16 -> normal S_DECODE, bus_err=0.
- opcode 1111111 -> S_HALT, illegal=1. Assert rst mid-S_MEM -> dmem_req drops immediately, illegal=0, state=S_IDLE then S_FETCH.
